// File: rtl/dmem_ctrl.sv
// Data-memory slave: word array behind a req/ack handshake, misaligned/out-of-range flagged on err.
// Latency: ack LATENCY cycles after the accepting edge; one transaction per LATENCY+1 cycles.
// Backpressure: requester holds req and fields until ack; inputs are ignored while a request is in flight.
module dmem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dmem_req_i,
    input  logic [DATA_WIDTH-1:0] dmem_addr_i,
    input  logic                  dmem_we_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rd_o,
    output logic                  dmem_ack_o,
    output logic                  dmem_err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   addr_q, wdata_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_q;
    logic                    ack_q, err_q;
    logic                    accept, commit;
    logic [DATA_WIDTH-1:0]   c_addr, c_wdata;
    logic                    c_we, c_err;
    logic [IDX_W-1:0]        c_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_req_i) begin
                    accept = 1'b1;
                    cnt_d  = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY == 1 the commit edge is the accepting edge, so use the live inputs there.
    always_comb begin
        c_addr  = (state_q == IDLE) ? dmem_addr_i  : addr_q;
        c_wdata = (state_q == IDLE) ? dmem_wdata_i : wdata_q;
        c_we    = (state_q == IDLE) ? dmem_we_i    : we_q;
        c_idx   = c_addr[IDX_W+1:2];
        c_err   = (|c_addr[1:0]) | (|(c_addr >> (IDX_W + 2)));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= commit;
            err_q   <= commit & c_err;
            if (accept) begin
                addr_q  <= dmem_addr_i;
                wdata_q <= dmem_wdata_i;
                we_q    <= dmem_we_i;
            end
            if (commit) begin
                if (c_err) begin
                    rd_q <= '0;
                end else if (c_we) begin
                    mem[c_idx] <= c_wdata;
                end else begin
                    rd_q <= mem[c_idx];
                end
            end
        end
    end

    assign dmem_rd_o  = rd_q;
    assign dmem_ack_o = ack_q;
    assign dmem_err_o = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed and randomised checks of dmem_ctrl at LATENCY 2 (directed), 1 and 3 (soak vs. array model).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic        ack   [3];
    logic        err   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rd    [3];

    int checks = 0;
    int errors = 0;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            dmem_ctrl #(
                .DATA_WIDTH(32),
                .DEPTH     (256),
                .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 1 : 3))
            ) u_dut (
                .clk_i       (clk),
                .rst_i       (rst),
                .dmem_req_i  (req[g]),
                .dmem_addr_i (addr[g]),
                .dmem_we_i   (we[g]),
                .dmem_wdata_i(wdata[g]),
                .dmem_rd_o   (rd[g]),
                .dmem_ack_o  (ack[g]),
                .dmem_err_o  (err[g])
            );
        end
    endgenerate

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge. b2b: previous call left req high, so one extra cycle before acceptance.
    task automatic txn(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_err, input bit b2b, input bit hold,
                       input string tag);
        int n;
        req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[u] && n < 40);
        chk({tag, "_lat"}, n, lat_of(u) + int'(b2b));
        chk({tag, "_err"}, {31'b0, err[u]}, {31'b0, exp_err});
        chk({tag, "_rd"}, rd[u], exp_rd);
        if (!hold) begin
            req[u] = 1'b0;
            @(negedge clk);
            chk({tag, "_ack1"}, {31'b0, ack[u]}, 32'd0);
            chk({tag, "_err1"}, {31'b0, err[u]}, 32'd0);
        end
    endtask

    logic [31:0] mdl [256];
    logic [31:0] m_rd, a, d, exp_rd;
    bit          w, e, hold, b2b;
    int          bit_i, r;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        repeat (20) begin
            @(negedge clk);
            chk("t1_ack", {31'b0, ack[0]}, 32'd0);
            chk("t1_err", {31'b0, err[0]}, 32'd0);
            chk("t1_rd", rd[0], 32'd0);
        end
        txn(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "t1_ld");

        // Store then load
        txn(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0, "t2_st");
        txn(0, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, "t2_ld");

        // Misaligned / out of range
        txn(0, 1'b1, 32'h4, 32'h5555_AAAA, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, "t3_st4");
        txn(0, 1'b1, 32'h6, 32'h1111_2222, 32'h0, 1'b1, 1'b0, 1'b0, "t3_mis");
        txn(0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "t3_oor");
        txn(0, 1'b0, 32'h4, 32'h0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, "t3_ld4");

        // Back-to-back loads with req held high
        txn(0, 1'b1, 32'h0, 32'h0BAD_F00D, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, "t4_st0");
        txn(0, 1'b1, 32'hC, 32'hC0FF_EE00, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, "t4_stc");
        txn(0, 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, "t4_ld0");
        txn(0, 1'b0, 32'h4, 32'h0, 32'h5555_AAAA, 1'b0, 1'b1, 1'b1, "t4_ld4");
        txn(0, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, "t4_ld8");
        txn(0, 1'b0, 32'hC, 32'h0, 32'hC0FF_EE00, 1'b0, 1'b1, 1'b0, "t4_ldc");

        // Reset during WAIT drops the store
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h1234_5678;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_ack_wait", {31'b0, ack[0]}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        req[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t5_noack", {31'b0, ack[0]}, 32'd0);
        end
        chk("t5_rd_rst", rd[0], 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "t5_ld");
        txn(0, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "t5_ldc");

        // Random soak against the array model at LATENCY 1 and 3
        for (int u = 1; u < 3; u++) begin
            for (int i = 0; i < 256; i++) mdl[i] = '0;
            m_rd = '0;
            b2b  = 1'b0;
            for (int t = 0; t < ((u == 1) ? 700 : 900); t++) begin
                r = $urandom_range(0, 99);
                a = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                if (r < 8) begin
                    a[1:0] = 2'($urandom_range(1, 3));
                end else if (r < 14) begin
                    bit_i = 10 + int'($urandom_range(0, 21));
                    a[bit_i] = 1'b1;
                end
                w    = 1'($urandom_range(0, 1));
                d    = $urandom;
                hold = ($urandom_range(0, 3) == 0) && (t != ((u == 1) ? 699 : 899));
                e    = (|a[1:0]) || (|a[31:10]);
                if (e)      exp_rd = '0;
                else if (w) begin mdl[a[9:2]] = d; exp_rd = m_rd; end
                else        exp_rd = mdl[a[9:2]];
                m_rd = exp_rd;
                txn(u, w, a, d, exp_rd, e, b2b, hold, (u == 1) ? "soak_l1" : "soak_l3");
                b2b = hold;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory slave directly downstream of the ALU load/store stage (alu_mem).
- Accepts that stage's dmem request (req/addr/we/wdata), services it from an internal word array after a fixed, parameterised latency, and returns read data with a one-cycle ack.
- Flags misaligned and out-of-range accesses with an error strobe coincident with ack.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data.
- DEPTH, 256, number of DATA_WIDTH-bit words in the array (power of two, ≥ 2).
- LATENCY, 2, cycles from request acceptance to ack (legal range 1..15).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- dmem_req_i  input  1  request valid; requester holds it and all request fields stable until ack.
- dmem_addr_i  input  DATA_WIDTH  byte address.
- dmem_we_i  input  1  1 = store, 0 = load.
- dmem_wdata_i  input  DATA_WIDTH  store data.
- dmem_rd_o  output  DATA_WIDTH  load data, registered; valid in the ack cycle and held until the next ack.
- dmem_ack_o  output  1  one-cycle completion strobe.
- dmem_err_o  output  1  error strobe; only ever high together with dmem_ack_o.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset, sampled at a clock edge:
  - state = IDLE; dmem_ack_o = 0; dmem_err_o = 0; dmem_rd_o = 0; latency counter = 0.
  - All DEPTH array words are cleared to 0.
  - Reset has priority over every other action on the same edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If dmem_req_i = 1 at an edge, latch addr, we and wdata, and load the counter with LATENCY-1.
  - Next state is RESP if LATENCY = 1, otherwise WAIT.
  - If req = 0, stay in IDLE.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0, move to RESP.
  - Request inputs are ignored while in WAIT; the latched copies are used.
- RESP:
  - dmem_ack_o = 1 for exactly one cycle.
  - Next state is IDLE unconditionally.
- Latency: a request first sampled at edge k produces dmem_ack_o high in the cycle after edge k+LATENCY-1, i.e. LATENCY cycles of delay.
- Throughput: at most one transaction per LATENCY+1 cycles. If req is still high in the IDLE cycle after RESP, it is treated as a new request.
- Address decode:
  - word index = addr[log2(DEPTH)+1:2].
  - Error if addr[1:0] ≠ 0 (misaligned), or if any addr bit above log2(DEPTH)+1 is nonzero (out of range).
- Commit happens on the edge entering RESP:
  - Store, no error: array[index] ← wdata; dmem_rd_o unchanged.
  - Load, no error: dmem_rd_o ← array[index].
  - Error: no array write; dmem_rd_o ← 0; dmem_err_o = 1 in the RESP cycle.
- Read-after-write: a load following a store to the same index returns the stored value. Each commit finishes before the next request is accepted, so no bypass is needed.
- Reset mid-operation: an in-flight request is dropped with no write and no ack. A req still high after reset deasserts is accepted as a fresh request.
- dmem_ack_o is never asserted without a prior accepted request.
- dmem_err_o is never high in a cycle where dmem_ack_o is low.

Test Plan:
1. Reset then idle: rst_i high 2 cycles, req = 0 for 20 cycles -> ack, err and rd all 0 throughout; load of addr 0x10 then returns 0.
2. Store then load, LATENCY = 2:
   - Store addr 0x0000_0008, wdata 0xDEAD_BEEF -> ack exactly 2 cycles after acceptance, err = 0.
   - Load 0x0000_0008 -> ack after 2 cycles, rd = 0xDEAD_BEEF.
3. Misaligned and out-of-range, DEPTH = 256:
   - Store to 0x0000_0006 -> ack with err = 1, no write.
   - Load 0x0000_0400 -> ack with err = 1, rd = 0.
   - Load 0x0000_0004 -> returns the prior contents, unchanged.
4. Back-to-back: req held high continuously across 4 loads to 0x0, 0x4, 0x8, 0xC (addr changed the cycle after each ack) -> acks spaced LATENCY+1 cycles apart, each returning its preloaded value.
5. Reset mid-op: store 0x0000_0010, 0x1234_5678 accepted, rst_i pulsed during WAIT -> no ack, array[4] = 0; a subsequent load of 0x10 returns 0.
6. Randomised soak against a reference array model: 5000 cycles of random we/addr (mostly in range and aligned), LATENCY = 1 and 3 -> every rd and err matches the model, acks appear only at the expected cycles, pass count equals the total.
